fetch_prefetch: RTL and testbench
=================================

Name: fetch_prefetch

Overview:
Instruction-fetch front end that drives the read port of the simulation memory model. It issues sequential word reads from a program counter and captures the 1-cycle-latency read data. Fetched words and their addresses go into a small prefetch FIFO that feeds decode through a valid/ready handshake. A redirect input (branch/jump) flushes the FIFO and discards any read still in flight.

Parameters:
AWIDTH, 16, address width in words; PC arithmetic is modulo 2^AWIDTH
DWIDTH, 16, instruction word width
DEPTH, 4, prefetch FIFO entries; power of two, >= 2
RESET_PC, 0, fetch address after reset

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = in reset)
mem_re  output  1  read enable to memory read port
mem_raddr  output  AWIDTH  read address to memory
mem_rdata  input  DWIDTH  read data; valid in the cycle after the cycle mem_re was high
out_valid  output  1  FIFO head holds a valid instruction
out_insn  output  DWIDTH  instruction word at FIFO head
out_pc  output  AWIDTH  address of out_insn
out_ready  input  1  decode accepts head this cycle
redirect  input  1  flush and restart fetch at redirect_pc
redirect_pc  input  AWIDTH  new fetch address, sampled when redirect=1

Behaviour:
- State: pc (next address to issue), pending flag plus pending_pc (read issued last cycle), FIFO of {pc, insn} with count 0..DEPTH.
- Reset (rst=0, async): pc=RESET_PC, pending=0, count=0, FIFO pointers=0. Outputs while in reset: mem_re=0, out_valid=0. out_insn and out_pc are don't-care.
- Issue (combinational): mem_re = !redirect && (count + pending < DEPTH); mem_raddr = pc. The same-cycle pop is not counted in the credit check, so the FIFO can never overflow.
- On an edge with mem_re=1: pc <= pc+1, wrapping 2^AWIDTH-1 -> 0; pending <= 1; pending_pc <= pc. Otherwise pending <= 0 (unless flushed, see below).
- Capture: on an edge with pending=1 and redirect=0, push {pending_pc, mem_rdata} into the FIFO.
- Read latency: an address issued in cycle N is captured at the end of cycle N+1 and appears at out_valid/out_insn in cycle N+2. Minimum issue-to-output latency is 2 cycles.
- Output: out_valid = (count != 0); out_insn and out_pc come from the head entry. Pop on an edge with out_valid && out_ready && !redirect.
- Push and pop in the same edge: count unchanged, both pointers advance.
- Throughput: with out_ready held at 1, one instruction per cycle in steady state. Requires DEPTH >= 2.
- Back-pressure: with out_ready=0, fetch stops once count + pending = DEPTH. No read is issued that lacks a guaranteed slot.
- Redirect (priority over all else) on an edge with redirect=1:
  - count <= 0, pointers reset, pending <= 0, so a response arriving this cycle is dropped;
  - pc <= redirect_pc;
  - no pop occurs; mem_re is 0 during the redirect cycle.
  - Fetch from redirect_pc issues in the next cycle.
- Back-to-back redirects: the last one wins; mem_re stays 0 while redirect is held.
- mem_rdata is ignored whenever pending=0.
- Reset asserted mid-operation: all state is cleared immediately, without waiting for a clock edge. The memory's stale rdata is ignored because pending=0.

Test Plan:
1. Reset release with RESET_PC=0x0100, out_ready=1, memory preloaded mem[0x0100+i]=0xA000+i -> mem_re high in the first cycle after release with raddr 0x0100, 0x0101, ... one per cycle. First out_valid arrives 2 cycles later with insn 0xA000, pc 0x0100, then one per cycle in order.
2. out_ready=0 from reset -> exactly DEPTH reads are issued (0x0100..0x0103), then mem_re=0 and count=4 hold steady. Raising out_ready drains 0xA000..0xA003 in order and fetch resumes at 0x0104 with no gaps or duplicates.
3. Redirect to 0x0200 while the FIFO holds 3 entries and a read is pending -> next cycle out_valid=0. The pending data is never output. The next mem_raddr is 0x0200, and the first output after that is pc 0x0200.
4. pc starting at 0xFFFE with AWIDTH=16 -> issued addresses are 0xFFFE, 0xFFFF, 0x0000, 0x0001, and out_pc follows the same wrap.
5. Redirect held for 3 cycles with changing redirect_pc (0x10, 0x20, 0x30) -> mem_re=0 throughout; fetch restarts at 0x30 only.
6. rst driven low between clock edges mid-stream -> out_valid and mem_re fall immediately. After release, fetch restarts at RESET_PC with no stale outputs.

Source files
------------

// File: rtl/fetch_prefetch.sv
// Instruction-fetch front end: issues sequential reads, captures 1-cycle-latency data
// into a small prefetch FIFO feeding decode, and flushes on redirect.
module fetch_prefetch #(
    parameter int                AWIDTH   = 16,
    parameter int                DWIDTH   = 16,
    parameter int                DEPTH    = 4,
    parameter logic [AWIDTH-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_re,
    output logic [AWIDTH-1:0] mem_raddr,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              out_valid,
    output logic [DWIDTH-1:0] out_insn,
    output logic [AWIDTH-1:0] out_pc,
    input  logic              out_ready,
    input  logic              redirect,
    input  logic [AWIDTH-1:0] redirect_pc
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [AWIDTH-1:0] pc_q, pc_d;
    logic [AWIDTH-1:0] pend_pc_q, pend_pc_d;
    logic              pend_q, pend_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;

    logic [AWIDTH-1:0] pc_mem   [DEPTH];
    logic [DWIDTH-1:0] insn_mem [DEPTH];

    logic [CW:0] used;
    logic        push;
    logic        pop;

    // The in-flight read reserves a slot; a same-cycle pop earns no credit.
    assign used      = {1'b0, count_q} + {{CW{1'b0}}, pend_q};
    assign mem_re    = rst && !redirect && (used < DEPTH_W);
    assign mem_raddr = pc_q;

    assign out_valid = (count_q != '0);
    assign out_insn  = insn_mem[rd_ptr_q];
    assign out_pc    = pc_mem[rd_ptr_q];

    assign push = pend_q && !redirect;
    assign pop  = out_valid && out_ready && !redirect;

    always_comb begin
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        pend_d    = 1'b0;
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        if (redirect) begin
            pc_d     = redirect_pc;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (mem_re) begin
                pc_d      = pc_q + AWIDTH'(1);
                pend_d    = 1'b1;
                pend_pc_d = pc_q;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q      <= RESET_PC;
            pend_pc_q <= '0;
            pend_q    <= 1'b0;
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
        end else begin
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            pend_q    <= pend_d;
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
        end
    end

    // Entry storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= pend_pc_q;
            insn_mem[wr_ptr_q] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: directed vector tables, hand-built corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_fetch_prefetch;

    localparam int          AW    = 16;
    localparam int          DW    = 16;
    localparam int          DEPTH = 4;
    localparam logic [15:0] RPC   = 16'h0100;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          mem_re;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata = '0;
    logic          out_valid;
    logic [DW-1:0] out_insn;
    logic [AW-1:0] out_pc;
    logic          out_ready = 1'b0;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_pc = '0;

    always #5 clk = ~clk;

    fetch_prefetch #(.AWIDTH(AW), .DWIDTH(DW), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_insn(out_insn), .out_pc(out_pc), .out_ready(out_ready),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    // Memory contents: mem[0x0100+i] = 0xA000+i, extended to the whole space.
    function automatic logic [15:0] memval(input logic [15:0] a);
        return a + 16'h9F00;
    endfunction

    // 1-cycle read latency; garbage when no read was issued.
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= memval(mem_raddr);
        else        mem_rdata <= 16'($urandom);
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] insn;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] m_pc   = RPC;
    logic [15:0] m_ppc  = '0;
    bit          m_pend = 1'b0;

    task automatic model_cycle();
        bit   exp_re;
        bit   do_pop;
        ent_t e;
        if (!rst) begin
            chk("m_rst_re", mem_re, 0);
            chk("m_rst_valid", out_valid, 0);
            mq.delete();
            m_pend = 1'b0;
            m_pc   = RPC;
            return;
        end
        exp_re = !redirect && ((mq.size() + int'(m_pend)) < DEPTH);
        chk("m_re", mem_re, exp_re);
        chk("m_raddr", mem_raddr, m_pc);
        chk("m_valid", out_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("m_pc", out_pc, mq[0].pc);
            chk("m_insn", out_insn, mq[0].insn);
        end
        if (redirect) begin
            mq.delete();
            m_pend = 1'b0;
            m_pc   = redirect_pc;
        end else begin
            do_pop = (mq.size() != 0) && out_ready;
            if (do_pop) void'(mq.pop_front());
            if (m_pend) begin
                e.pc   = m_ppc;
                e.insn = memval(m_ppc);
                mq.push_back(e);
            end
            if (mq.size() > DEPTH) chk("m_overflow", mq.size(), DEPTH);
            m_pend = exp_re;
            if (exp_re) begin
                m_ppc = m_pc;
                m_pc  = m_pc + 16'd1;
            end
        end
    endtask

    task automatic run(input bit r, input bit rdy, input bit rdr, input logic [15:0] rpc);
        rst         = r;
        out_ready   = rdy;
        redirect    = rdr;
        redirect_pc = rpc;
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          r;
        bit          rdy;
        bit          rdr;
        logic [15:0] rpc;
        bit          e_re;
        logic [15:0] e_addr;
        bit          e_v;
        logic [15:0] e_pc;
        logic [15:0] e_insn;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, input bit rdy, input bit rdr, input logic [15:0] rpc,
                       input bit e_re, input logic [15:0] e_addr,
                       input bit e_v, input logic [15:0] e_pc, input logic [15:0] e_insn);
        vec_t v;
        v.r = r; v.rdy = rdy; v.rdr = rdr; v.rpc = rpc;
        v.e_re = e_re; v.e_addr = e_addr; v.e_v = e_v; v.e_pc = e_pc; v.e_insn = e_insn;
        tbl.push_back(v);
    endtask

    initial begin
        // Streaming from reset with decode always ready
        add(0,1,0,0,     0,16'h0000, 0,16'h0000,16'h0000);
        add(1,1,0,0,     1,16'h0100, 0,16'h0000,16'h0000);
        add(1,1,0,0,     1,16'h0101, 0,16'h0000,16'h0000);
        add(1,1,0,0,     1,16'h0102, 1,16'h0100,16'hA000);
        add(1,1,0,0,     1,16'h0103, 1,16'h0101,16'hA001);
        add(1,1,0,0,     1,16'h0104, 1,16'h0102,16'hA002);
        add(1,1,0,0,     1,16'h0105, 1,16'h0103,16'hA003);
        // Back-pressure: exactly DEPTH reads, hold, then drain and resume
        add(0,0,0,0,     0,16'h0000, 0,16'h0000,16'h0000);
        add(1,0,0,0,     1,16'h0100, 0,16'h0000,16'h0000);
        add(1,0,0,0,     1,16'h0101, 0,16'h0000,16'h0000);
        add(1,0,0,0,     1,16'h0102, 1,16'h0100,16'hA000);
        add(1,0,0,0,     1,16'h0103, 1,16'h0100,16'hA000);
        add(1,0,0,0,     0,16'h0104, 1,16'h0100,16'hA000);
        add(1,0,0,0,     0,16'h0104, 1,16'h0100,16'hA000);
        add(1,0,0,0,     0,16'h0104, 1,16'h0100,16'hA000);
        add(1,1,0,0,     0,16'h0104, 1,16'h0100,16'hA000);
        add(1,1,0,0,     1,16'h0104, 1,16'h0101,16'hA001);
        add(1,1,0,0,     1,16'h0105, 1,16'h0102,16'hA002);
        add(1,1,0,0,     1,16'h0106, 1,16'h0103,16'hA003);
        add(1,1,0,0,     1,16'h0107, 1,16'h0104,16'hA004);
        // Redirect with 3 entries queued and a read in flight
        add(0,0,0,0,     0,16'h0000, 0,16'h0000,16'h0000);
        add(1,0,0,0,     1,16'h0100, 0,16'h0000,16'h0000);
        add(1,0,0,0,     1,16'h0101, 0,16'h0000,16'h0000);
        add(1,0,0,0,     1,16'h0102, 1,16'h0100,16'hA000);
        add(1,0,0,0,     1,16'h0103, 1,16'h0100,16'hA000);
        add(1,0,1,16'h0200, 0,16'h0104, 1,16'h0100,16'hA000);
        add(1,0,0,0,     1,16'h0200, 0,16'h0000,16'h0000);
        add(1,0,0,0,     1,16'h0201, 0,16'h0000,16'h0000);
        add(1,0,0,0,     1,16'h0202, 1,16'h0200,16'hA100);
        add(1,1,0,0,     1,16'h0203, 1,16'h0200,16'hA100);
        add(1,1,0,0,     1,16'h0204, 1,16'h0201,16'hA101);

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            rst         = tbl[i].r;
            out_ready   = tbl[i].rdy;
            redirect    = tbl[i].rdr;
            redirect_pc = tbl[i].rpc;
            @(negedge clk);
            if (!tbl[i].r) begin
                chk("tbl_rst_re", mem_re, 0);
                chk("tbl_rst_valid", out_valid, 0);
            end else begin
                chk("tbl_re", mem_re, tbl[i].e_re);
                chk("tbl_raddr", mem_raddr, tbl[i].e_addr);
                chk("tbl_valid", out_valid, tbl[i].e_v);
                if (tbl[i].e_v) begin
                    chk("tbl_pc", out_pc, tbl[i].e_pc);
                    chk("tbl_insn", out_insn, tbl[i].e_insn);
                end
            end
            model_cycle();
            @(posedge clk);
            #1;
        end

        // Address wrap at the top of the space
        run(1, 1, 1, 16'hFFFE);
        for (int i = 0; i < 8; i++) run(1, 1, 0, 0);

        // Redirect held three cycles; only the last target is fetched
        run(1, 1, 1, 16'h0010);
        run(1, 1, 1, 16'h0020);
        run(1, 1, 1, 16'h0030);
        for (int i = 0; i < 6; i++) run(1, 1, 0, 0);

        // Asynchronous reset between edges mid-stream
        chk("pre_async_valid", out_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_re", mem_re, 0);
        chk("async_valid", out_valid, 0);
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) run(1, 1, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            run(($urandom_range(0, 299) != 0),
                ($urandom_range(0, 9) < 7),
                ($urandom_range(0, 19) == 0),
                16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
